// File: rtl/k6502_seq.sv
// Instruction-cycle sequencer: one-hot cycle vector, opcode latch and
// RST/NMI/IRQ interrupt-select generation for the microcode ROM.
module k6502_seq #(
    parameter int unsigned CYC_BITS = 6,
    parameter logic [7:0]  RESET_IR = 8'h00
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic [7:0]          di,
    input  logic                sync_next,
    input  logic                i_flag,
    input  logic                nmi,
    input  logic                irq,
    output logic [7:0]          ir,
    output logic [CYC_BITS-1:0] cycle,
    output logic [2:0]          int_sel,
    output logic                sync,
    output logic                seq_err
);

    typedef enum logic [2:0] {
        SEL_NONE = 3'b000,
        SEL_IRQ  = 3'b001,
        SEL_NMI  = 3'b010,
        SEL_RST  = 3'b100
    } sel_e;

    logic [7:0]          ir_q, ir_d;
    logic [CYC_BITS-1:0] cyc_q, cyc_d;
    sel_e                sel_q, sel_d;
    logic                nmi_pend_q, nmi_pend_d;
    logic                nmi_prev_q;
    logic                seq_err_q, seq_err_d;
    logic                nmi_edge;

    assign nmi_edge = nmi & ~nmi_prev_q;

    always_comb begin
        ir_d       = ir_q;
        cyc_d      = cyc_q;
        sel_d      = sel_q;
        seq_err_d  = seq_err_q;
        nmi_pend_d = nmi_pend_q;

        if (rdy) begin
            seq_err_d = 1'b0;
            if (cyc_q == '0) begin
                ir_d  = di;
                cyc_d = CYC_BITS'(1);
            end else if (sync_next) begin
                if (nmi_pend_q) begin
                    sel_d      = SEL_NMI;
                    cyc_d      = CYC_BITS'(1);
                    nmi_pend_d = 1'b0;
                end else if (irq && !i_flag) begin
                    sel_d = SEL_IRQ;
                    cyc_d = CYC_BITS'(1);
                end else begin
                    sel_d = SEL_NONE;
                    cyc_d = '0;
                end
            end else if (cyc_q[CYC_BITS-1]) begin
                sel_d     = SEL_NONE;
                cyc_d     = '0;
                seq_err_d = 1'b1;
            end else begin
                cyc_d = cyc_q << 1;
            end
        end

        // A fresh edge wins over a same-cycle consume, so it is serviced next boundary.
        if (nmi_edge) begin
            nmi_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        nmi_prev_q <= nmi;
        if (rst) begin
            ir_q       <= RESET_IR;
            cyc_q      <= CYC_BITS'(1);
            sel_q      <= SEL_RST;
            nmi_pend_q <= 1'b0;
            seq_err_q  <= 1'b0;
        end else begin
            ir_q       <= ir_d;
            cyc_q      <= cyc_d;
            sel_q      <= sel_d;
            nmi_pend_q <= nmi_pend_d;
            seq_err_q  <= seq_err_d;
        end
    end

    assign ir      = ir_q;
    assign cycle   = cyc_q;
    assign int_sel = sel_q;
    assign seq_err = seq_err_q;
    assign sync    = (cyc_q == '0) && (sel_q == SEL_NONE);

endmodule

// File: tb/tb_k6502_seq.sv
// Self-checking bench for k6502_seq: directed scenarios followed by random
// stimulus, all compared against a cycle-index reference model.
module tb_k6502_seq;

    localparam int unsigned CB = 6;

    logic          clk;
    logic          rst_r, rdy_r, sn_r, ifl_r, nmi_r, irq_r;
    logic [7:0]    di_r;
    logic [7:0]    ir;
    logic [CB-1:0] cycle;
    logic [2:0]    int_sel;
    logic          sync, seq_err;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: cycle as an index (-1 = C_N), int_sel as a plain code.
    int       m_idx  = 0;
    int       m_sel  = 0;
    bit [7:0] m_ir   = 8'h00;
    bit       m_pend = 0;
    bit       m_prev = 0;
    bit       m_err  = 0;

    k6502_seq #(.CYC_BITS(CB), .RESET_IR(8'h00)) dut (
        .clk      (clk),
        .rst      (rst_r),
        .rdy      (rdy_r),
        .di       (di_r),
        .sync_next(sn_r),
        .i_flag   (ifl_r),
        .nmi      (nmi_r),
        .irq      (irq_r),
        .ir       (ir),
        .cycle    (cycle),
        .int_sel  (int_sel),
        .sync     (sync),
        .seq_err  (seq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_step();
        bit edge_seen;
        edge_seen = nmi_r && !m_prev;
        m_prev    = nmi_r;
        if (rst_r) begin
            m_ir = 8'h00; m_idx = 0; m_sel = 4; m_pend = 0; m_err = 0;
        end else begin
            if (rdy_r) begin
                m_err = 0;
                if (m_idx < 0) begin
                    m_ir  = di_r;
                    m_idx = 0;
                end else if (sn_r) begin
                    if (m_pend) begin
                        m_sel = 2; m_idx = 0; m_pend = 0;
                    end else if (irq_r && !ifl_r) begin
                        m_sel = 1; m_idx = 0;
                    end else begin
                        m_sel = 0; m_idx = -1;
                    end
                end else if (m_idx == CB - 1) begin
                    m_sel = 0; m_idx = -1; m_err = 1;
                end else begin
                    m_idx = m_idx + 1;
                end
            end
            if (edge_seen) m_pend = 1;
        end
    endtask

    task automatic tick();
        logic [31:0] exp_cyc;
        @(posedge clk);
        model_step();
        #1;
        exp_cyc = (m_idx < 0) ? 32'd0 : (32'd1 << m_idx);
        chk("ir", 32'(ir), 32'(m_ir));
        chk("cycle", 32'(cycle), exp_cyc);
        chk("int_sel", 32'(int_sel), 32'(m_sel));
        chk("sync", 32'(sync), 32'((m_idx < 0) && (m_sel == 0)));
        chk("seq_err", 32'(seq_err), 32'(m_err));
    endtask

    // Drive sync_next in the cycle whose index equals 'last'; bounded wait.
    task automatic run_to(input int last);
        bit done;
        done = 0;
        for (int i = 0; i < 12 && !done; i++) begin
            sn_r = (m_idx == last);
            done = sn_r;
            tick();
        end
        sn_r = 0;
        chk("run_to_done", 32'(done), 32'd1);
    endtask

    initial begin
        int  pulses;
        bit  done;
        rst_r = 1; rdy_r = 1; sn_r = 0; ifl_r = 1; nmi_r = 0; irq_r = 0; di_r = 8'h00;
        #2;

        // Reset then vector load ending at C_4
        tick();
        chk("rst_cycle", 32'(cycle), 32'd1);
        chk("rst_sel", 32'(int_sel), 32'd4);
        tick();
        rst_r = 0;
        run_to(4);
        chk("vec_sync", 32'(sync), 32'd1);
        chk("vec_sel", 32'(int_sel), 32'd0);

        // INX: fetch E8, two cycles
        di_r = 8'hE8; tick();
        chk("inx_ir", 32'(ir), 32'hE8);
        run_to(1);
        chk("inx_end_cycle", 32'(cycle), 32'd0);

        // LDA abs with NMI rising in C_1
        di_r = 8'hAD; tick();
        done = 0;
        for (int i = 0; i < 8 && !done; i++) begin
            nmi_r = (m_idx >= 1);
            sn_r  = (m_idx == 3);
            done  = sn_r;
            tick();
        end
        sn_r = 0;
        chk("nmi_sel", 32'(int_sel), 32'd2);
        chk("nmi_cycle", 32'(cycle), 32'd1);
        chk("nmi_ir", 32'(ir), 32'hAD);
        // second edge inside the NMI sequence, serviced at its end
        nmi_r = 0; tick();
        nmi_r = 1; tick();
        run_to(3);
        chk("nmi2_sel", 32'(int_sel), 32'd2);

        // IRQ masked, then unmasked
        irq_r = 1; ifl_r = 1;
        run_to(2);
        chk("irq_masked_sel", 32'(int_sel), 32'd0);
        di_r = 8'hEA; tick();
        ifl_r = 0;
        run_to(1);
        chk("irq_sel", 32'(int_sel), 32'd1);
        irq_r = 0; ifl_r = 1;
        run_to(3);

        // rdy stall in C_1 with toggling sync_next and an NMI edge
        nmi_r = 0;
        di_r = 8'hEA; tick();
        tick();
        rdy_r = 0;
        for (int i = 0; i < 3; i++) begin
            sn_r  = i[0];
            nmi_r = (i >= 1);
            tick();
            chk("stall_cycle", 32'(cycle), 32'd2);
        end
        rdy_r = 1; sn_r = 1; tick(); sn_r = 0;
        chk("stall_nmi_sel", 32'(int_sel), 32'd2);
        run_to(2);

        // overflow: no sync_next from C_N for 8 cycles
        pulses = 0;
        di_r = 8'h02;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (seq_err) pulses++;
        end
        chk("ovf_pulses", 32'(pulses), 32'd1);

        // reset in C_2 of STA abs
        run_to(2);
        di_r = 8'h8D; tick(); tick(); tick();
        rst_r = 1; tick(); rst_r = 0;
        chk("midrst_cycle", 32'(cycle), 32'd1);
        chk("midrst_sel", 32'(int_sel), 32'd4);
        chk("midrst_ir", 32'(ir), 32'd0);

        // randomized
        for (int i = 0; i < 3000; i++) begin
            rst_r = ($urandom_range(0, 63) == 0);
            rdy_r = ($urandom_range(0, 3) != 0);
            sn_r  = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) nmi_r = ~nmi_r;
            irq_r = ($urandom_range(0, 2) == 0);
            ifl_r = $urandom_range(0, 1);
            di_r  = 8'($urandom);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
